// File: rtl/neuron_pkg.sv
// Shared types and helpers for the multi-lane neuron MAC.
// Saturating add works in a wide signed domain, then clamps to w bits.
package neuron_pkg;

   localparam int DRAIN_CYCLES = 3;
   localparam int DRN_W        = $clog2(DRAIN_CYCLES);
   localparam int SW           = 96;

   typedef enum logic [1:0] {
      ACT_IDENT = 2'd0,
      ACT_RELU  = 2'd1,
      ACT_LEAKY = 2'd2
   } act_sel_e;

   typedef enum logic [2:0] {
      ST_ACCEPT,
      ST_DRAIN,
      ST_BIAS,
      ST_ACT,
      ST_OUT
   } neuron_state_e;

   typedef struct packed {
      logic [SW-1:0] v;
      logic          ovf;
   } sat_t;

   function automatic sat_t sat_add(
      input logic signed [SW-1:0] a,
      input logic signed [SW-1:0] b,
      input int                   w
   );
      logic signed [SW-1:0] s;
      logic signed [SW-1:0] hi;
      logic signed [SW-1:0] lo;
      s  = a + b;
      hi = (SW'(1) <<< (w - 1)) - SW'(1);
      lo = ~hi;
      sat_add.ovf = (s > hi) || (s < lo);
      if (s > hi)
         sat_add.v = hi;
      else if (s < lo)
         sat_add.v = lo;
      else
         sat_add.v = s;
   endfunction

endpackage

// File: rtl/neuron_wmem.sv
// Weight store: one write port, one synchronous read-first read port.
// Writes beyond DEPTH are dropped.
module neuron_wmem #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 196,
   parameter int AW    = 8
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_q, rd_d;
   logic             wr_ok;

   assign wr_ok = wr_en && ({1'b0, wr_addr} < (AW+1)'(DEPTH));

   always_comb begin
      rd_d = rd_q;
      if (rd_en)
         rd_d = mem_q[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (wr_ok)
         mem_q[wr_addr] <= wr_data;
      rd_q <= rd_d;
   end

   assign rd_data = rd_q;

endmodule

// File: rtl/neuron_mac_lanes.sv
// LANES-wide saturating MAC neuron with bias and selectable activation.
// Optional sat_flag output under NEURON_SAT_FLAG_EN.
module neuron_mac_lanes
   import neuron_pkg::*;
#(
   parameter int NUM_WEIGHT = 784,
   parameter int LANES      = 4,
   parameter int DATA_W     = 16,
   parameter int FRAC_W     = 14,
   parameter int ACC_W      = 32,
   parameter int LEAK_SHIFT = 3,
   localparam int BEATS     = NUM_WEIGHT / LANES,
   localparam int AW        = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [LANES*DATA_W-1:0] s_data,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic                    w_wr_en,
   input  logic [AW-1:0]           w_wr_addr,
   input  logic [LANES*DATA_W-1:0] w_wr_data,
   input  logic                    b_wr_en,
   input  logic [DATA_W-1:0]       b_wr_data,
   input  logic [1:0]              act_sel,
   output logic [DATA_W-1:0]       m_data,
   output logic                    m_valid,
   input  logic                    m_ready
`ifdef NEURON_SAT_FLAG_EN
   ,
   output logic                    sat_flag
`endif
);

   localparam int PW = 2 * DATA_W;

   neuron_state_e state_q, state_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic [DRN_W-1:0] drn_q, drn_d;

   logic                    v1_q, v1_d, v2_q, v2_d;
   logic [LANES*DATA_W-1:0] x1_q, x1_d, w1;
   logic [LANES-1:0][PW-1:0] p_q, p_d;
   logic [ACC_W-1:0]  acc_q, acc_d, sum_q, sum_d;
   logic [DATA_W-1:0] bias_q, bias_d, m_data_q, m_data_d;
   logic              m_valid_q, m_valid_d;
   logic              hs;

   logic signed [SW-1:0] lsum, acc_ext, bias_ext, sum_ext;
   logic signed [DATA_W-1:0] ys, act_y;
   sat_t acc_r, bias_r, act_r;

   assign hs = s_valid && s_ready;

   neuron_wmem #(
      .WIDTH(LANES*DATA_W),
      .DEPTH(BEATS),
      .AW   (AW)
   ) u_wmem (
      .clk    (clk),
      .wr_en  (w_wr_en),
      .wr_addr(w_wr_addr),
      .wr_data(w_wr_data),
      .rd_en  (hs),
      .rd_addr(cnt_q),
      .rd_data(w1)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_ACCEPT;
         cnt_q   <= '0;
         drn_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drn_q   <= drn_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      drn_d   = '0;
      unique case (state_q)
         ST_ACCEPT: if (hs) begin
            if (cnt_q == AW'(BEATS - 1)) begin
               cnt_d   = '0;
               state_d = ST_DRAIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            drn_d = drn_q + 1'b1;
            if (drn_q == DRN_W'(DRAIN_CYCLES - 1))
               state_d = ST_BIAS;
         end
         ST_BIAS: state_d = ST_ACT;
         ST_ACT:  state_d = ST_OUT;
         ST_OUT:  if (m_ready) state_d = ST_ACCEPT;
         default: state_d = ST_ACCEPT;
      endcase
   end

   always_comb begin
      s_ready = (state_q == ST_ACCEPT);
      m_valid = m_valid_q;
      m_data  = m_data_q;
   end

   // Lane products sign-extended into the wide domain before summing.
   always_comb begin
      lsum = '0;
      for (int i = 0; i < LANES; i++)
         lsum = lsum + {{(SW-PW){p_q[i][PW-1]}}, p_q[i]};
   end

   assign acc_ext  = {{(SW-ACC_W){acc_q[ACC_W-1]}}, acc_q};
   assign bias_ext = {{(SW-DATA_W){bias_q[DATA_W-1]}}, bias_q} <<< FRAC_W;
   assign sum_ext  = {{(SW-ACC_W){sum_q[ACC_W-1]}}, sum_q};
   assign acc_r    = sat_add(acc_ext, lsum, ACC_W);
   assign bias_r   = sat_add(acc_ext, bias_ext, ACC_W);
   assign act_r    = sat_add(sum_ext >>> FRAC_W, '0, DATA_W);
   assign ys       = act_r.v[DATA_W-1:0];

   always_comb begin
      act_y = ys;
      unique case (1'b1)
         (act_sel == ACT_RELU):  act_y = (ys < 0) ? '0 : ys;
         (act_sel == ACT_LEAKY): act_y = (ys < 0) ? (ys >>> LEAK_SHIFT) : ys;
         default:                act_y = ys;
      endcase
   end

   always_comb begin
      v1_d = hs;
      x1_d = hs ? s_data : x1_q;
      v2_d = v1_q;
      for (int i = 0; i < LANES; i++)
         p_d[i] = {{DATA_W{x1_q[i*DATA_W+DATA_W-1]}}, x1_q[i*DATA_W +: DATA_W]}
                * {{DATA_W{w1[i*DATA_W+DATA_W-1]}}, w1[i*DATA_W +: DATA_W]};
      acc_d     = acc_q;
      sum_d     = sum_q;
      bias_d    = b_wr_en ? b_wr_data : bias_q;
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      if (v2_q)
         acc_d = acc_r.v[ACC_W-1:0];
      if (state_q == ST_BIAS)
         sum_d = bias_r.v[ACC_W-1:0];
      if (state_q == ST_ACT) begin
         m_data_d  = act_y;
         m_valid_d = 1'b1;
      end
      if (state_q == ST_OUT && m_ready) begin
         m_valid_d = 1'b0;
         acc_d     = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         x1_q      <= '0;
         p_q       <= '0;
         acc_q     <= '0;
         sum_q     <= '0;
         bias_q    <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
      end else begin
         v1_q      <= v1_d;
         v2_q      <= v2_d;
         x1_q      <= x1_d;
         p_q       <= p_d;
         acc_q     <= acc_d;
         sum_q     <= sum_d;
         bias_q    <= bias_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
      end
   end

   logic unused_bits;

`ifdef NEURON_SAT_FLAG_EN
   logic sat_q, sat_d;

   always_comb begin
      sat_d = sat_q;
      if (v2_q && acc_r.ovf)
         sat_d = 1'b1;
      if (state_q == ST_BIAS && bias_r.ovf)
         sat_d = 1'b1;
      if (state_q == ST_ACT && act_r.ovf)
         sat_d = 1'b1;
      if (state_q == ST_OUT && m_ready)
         sat_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         sat_q <= 1'b0;
      else
         sat_q <= sat_d;
   end

   assign sat_flag    = sat_q && m_valid_q;
   assign unused_bits = ^{acc_r.v[SW-1:ACC_W], bias_r.v[SW-1:ACC_W],
                          act_r.v[SW-1:DATA_W]};
`else
   assign unused_bits = ^{acc_r.v[SW-1:ACC_W], bias_r.v[SW-1:ACC_W],
                          act_r.v[SW-1:DATA_W], acc_r.ovf, bias_r.ovf,
                          act_r.ovf};
`endif

endmodule

// File: tb/tb_neuron_mac_lanes.sv
// Directed self-checking bench for neuron_mac_lanes (LANES=4, 12 weights).
// Define NEURON_SAT_FLAG_EN to also check sat_flag.
module tb_neuron_mac_lanes;

   localparam int NW = 12;
   localparam int LN = 4;
   localparam int DW = 16;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rstn;
   logic [LN*DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic          w_wr_en;
   logic [AW-1:0] w_wr_addr;
   logic [LN*DW-1:0] w_wr_data;
   logic          b_wr_en;
   logic [DW-1:0] b_wr_data;
   logic [1:0]    act_sel;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
`ifdef NEURON_SAT_FLAG_EN
   logic          sat_flag;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   neuron_mac_lanes #(
      .NUM_WEIGHT(NW),
      .LANES     (LN),
      .DATA_W    (DW),
      .FRAC_W    (14),
      .ACC_W     (32),
      .LEAK_SHIFT(3)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .w_wr_en  (w_wr_en),
      .w_wr_addr(w_wr_addr),
      .w_wr_data(w_wr_data),
      .b_wr_en  (b_wr_en),
      .b_wr_data(b_wr_data),
      .act_sel  (act_sel),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready)
`ifdef NEURON_SAT_FLAG_EN
      ,
      .sat_flag (sat_flag)
`endif
   );

   function automatic logic [LN*DW-1:0] pk(
      input logic [15:0] l0, input logic [15:0] l1,
      input logic [15:0] l2, input logic [15:0] l3
   );
      return {l3, l2, l1, l0};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_w(input logic [AW-1:0] a, input logic [LN*DW-1:0] d);
      w_wr_en = 1'b1; w_wr_addr = a; w_wr_data = d;
      tick();
      w_wr_en = 1'b0;
   endtask

   task automatic wr_all(input logic [LN*DW-1:0] d);
      for (int a = 0; a < NW / LN; a++)
         wr_w(AW'(a), d);
   endtask

   task automatic wr_b(input logic [DW-1:0] b);
      b_wr_en = 1'b1; b_wr_data = b;
      tick();
      b_wr_en = 1'b0;
   endtask

   task automatic send(input logic [LN*DW-1:0] d);
      int n;
      n = 0;
      s_data = d; s_valid = 1'b1;
      while (!s_ready && n < 200) begin
         tick();
         n++;
      end
      if (!s_ready) begin
         checks++; errors++;
         $error("FAIL send_timeout: observed s_ready 0 expected 1");
      end
      tick();
      s_valid = 1'b0;
   endtask

   task automatic vec(input logic [LN*DW-1:0] d);
      for (int b = 0; b < NW / LN; b++)
         send(d);
   endtask

   task automatic result(input string tag, input logic [DW-1:0] exp,
                         input logic exp_sat);
      int n;
      n = 0;
      while (!m_valid && n < 50) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, 32'(m_valid), 32'd1);
      check({tag, "_data"}, 32'(m_data), 32'(exp));
`ifdef NEURON_SAT_FLAG_EN
      check({tag, "_sat"}, 32'(sat_flag), 32'(exp_sat));
`else
      if (exp_sat === 1'bx) $display("unreachable");
`endif
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      check({tag, "_drop"}, 32'(m_valid), 32'd0);
   endtask

   logic [LN*DW-1:0] mix_w, mix_x;

   initial begin
      rstn = 1'b0; s_data = '0; s_valid = 1'b0; w_wr_en = 1'b0;
      w_wr_addr = '0; w_wr_data = '0; b_wr_en = 1'b0; b_wr_data = '0;
      act_sel = 2'd1; m_ready = 1'b0;
      mix_w = pk(16'h4000, 16'h2000, 16'hC000, 16'h0000);
      mix_x = pk(16'h1000, 16'h0800, 16'h0400, 16'h7FFF);
      tick(); tick();
      check("rst_s_ready", 32'(s_ready), 32'd1);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      rstn = 1'b1;
      tick();

      // 12 x 0.5 x 1.0 = 6.0 clamps; m_valid on 5th edge after last beat
      wr_all(pk(16'h4000, 16'h4000, 16'h4000, 16'h4000));
      send(pk(16'h2000, 16'h2000, 16'h2000, 16'h2000));
      send(pk(16'h2000, 16'h2000, 16'h2000, 16'h2000));
      send(pk(16'h2000, 16'h2000, 16'h2000, 16'h2000));
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k == 1) check("drain_s_ready", 32'(s_ready), 32'd0);
         if (k == 4) check("lat_early", 32'(m_valid), 32'd0);
      end
      check("lat_edge5", 32'(m_valid), 32'd1);
      result("pos_clamp", 16'h7FFF, 1'b1);

      // -1.5 + 0.25 bias = -1.25 under each activation
      act_sel = 2'd0;
      vec(pk(16'hF800, 16'hF800, 16'hF800, 16'hF800));
      wr_b(16'h1000);
      result("ident", 16'hB000, 1'b0);
      act_sel = 2'd1;
      vec(pk(16'hF800, 16'hF800, 16'hF800, 16'hF800));
      result("relu", 16'h0000, 1'b0);
      act_sel = 2'd2;
      vec(pk(16'hF800, 16'hF800, 16'hF800, 16'hF800));
      result("leaky", 16'hF600, 1'b0);
      act_sel = 2'd3;
      vec(pk(16'hF800, 16'hF800, 16'hF800, 16'hF800));
      result("rsvd", 16'hB000, 1'b0);

      // accumulator saturation both directions
      act_sel = 2'd0;
      wr_b(16'h0000);
      wr_all(pk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF));
      vec(pk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF));
      result("acc_pos", 16'h7FFF, 1'b1);
      vec(pk(16'h8000, 16'h8000, 16'h8000, 16'h8000));
      result("acc_neg", 16'h8000, 1'b1);
      act_sel = 2'd1;
      vec(pk(16'h8000, 16'h8000, 16'h8000, 16'h8000));
      result("acc_neg_relu", 16'h0000, 1'b1);

      // per-lane weights, then negative bias
      act_sel = 2'd0;
      wr_all(mix_w);
      vec(mix_x);
      result("lanes", 16'h3000, 1'b0);
      wr_b(16'hE000);
      vec(mix_x);
      result("neg_bias", 16'h1000, 1'b0);
      wr_b(16'h0000);

      // output backpressure with a waiting source beat
      vec(mix_x);
      while (!m_valid) tick();
      s_data = mix_x; s_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         check("bp_s_ready", 32'(s_ready), 32'd0);
         check("bp_m_data", 32'(m_data), 32'h3000);
         tick();
      end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      vec(mix_x);
      result("bp_next", 16'h3000, 1'b0);

      // beat-0 rewrite on the same edge as its read, plus bubbles
      w_wr_en = 1'b1; w_wr_addr = '0; w_wr_data = '0;
      send(mix_x);
      w_wr_en = 1'b0;
      tick(); tick(); tick();
      send(mix_x);
      tick(); tick();
      send(mix_x);
      result("hazard_old", 16'h3000, 1'b0);
      send(mix_x);
      tick();
      send(mix_x);
      send(mix_x);
      result("hazard_new", 16'h2000, 1'b0);

      // reset mid-vector discards the partial sum
      wr_w(2'd0, mix_w);
      send(pk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF));
      send(pk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF));
      rstn = 1'b0;
      tick();
      check("mid_rst_s_ready", 32'(s_ready), 32'd1);
      check("mid_rst_m_valid", 32'(m_valid), 32'd0);
      rstn = 1'b1;
      tick();
      vec(mix_x);
      result("after_rst", 16'h3000, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
